// File: rtl/winograd_pkg.sv
// rtl/winograd_pkg.sv - shared constants, FSM state and tile tag types for the Winograd output sequencer
// Contents: element/tile widths, coordinate width, sequencer state enum, (x,y) tile tag struct.
package winograd_pkg;

    localparam int W        = 16;       // element width
    localparam int CW       = 8;        // tile dimension / coordinate width
    localparam int ROW_W    = 4 * W;    // one M row
    localparam int TILE_M_W = 16 * W;   // 4x4 M tile
    localparam int TILE_Y_W = 4 * W;    // 2x2 Y tile

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } tile_tag_t;

endpackage

// File: rtl/tile_out_fifo.sv
// rtl/tile_out_fifo.sv - synchronous output FIFO with registered occupancy count
// Ports: clk, rstn (async active-low), push/din write side, pop/dout/not_empty read side,
//        count = registered number of stored entries. dout reads 0 while empty.
module tile_out_fifo #(
    parameter int DW    = 80,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [DW-1:0]              din,
    input  logic                       pop,
    output logic [DW-1:0]              dout,
    output logic                       not_empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_pop;

    // Pop is ignored when empty; push relies on the caller's credit scheme
    // (a push into a full FIFO only ever coincides with a pop).
    assign do_pop = pop & (cnt_q != '0);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign not_empty = (cnt_q != '0);
    assign dout      = not_empty ? mem_q[rd_q] : '0;
    assign count     = cnt_q;

endmodule

// File: rtl/winograd_output_sequencer.sv
// rtl/winograd_output_sequencer.sv - sequences the F(2x2,3x3) output transform over a tiled feature map
// Ports: clk, rstn (async active-low); start/tiles_w/tiles_h frame control;
//        m_valid/m_ready/m_row product-row intake; xf_M tile to transform, xf_Y transform result;
//        y_valid/y_ready/y_data/y_tile_x/y_tile_y tagged Y tile output; busy, frame_done status.
module winograd_output_sequencer
    import winograd_pkg::*;
#(
    parameter int XF_LAT    = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [CW-1:0]       tiles_w,
    input  logic [CW-1:0]       tiles_h,
    input  logic                m_valid,
    output logic                m_ready,
    input  logic [ROW_W-1:0]    m_row,
    output logic [TILE_M_W-1:0] xf_M,
    input  logic [TILE_Y_W-1:0] xf_Y,
    output logic                y_valid,
    input  logic                y_ready,
    output logic [TILE_Y_W-1:0] y_data,
    output logic [CW-1:0]       y_tile_x,
    output logic [CW-1:0]       y_tile_y,
    output logic                busy,
    output logic                frame_done
);

    localparam int CNT_W  = $clog2(OUT_DEPTH) + 1;
    localparam int OCC_W  = CNT_W + 1;
    localparam int FIFO_W = TILE_Y_W + 2 * CW;

    seq_state_t             state_q, state_d;
    logic [1:0]             row_cnt_q, row_cnt_d;
    logic [3*ROW_W-1:0]     rows_q, rows_d;      // rows 0..2 of the tile being gathered, row 0 in MSBs
    logic [TILE_M_W-1:0]    xf_m_q, xf_m_d;
    logic [CW-1:0]          w_q, w_d, h_q, h_d;
    logic [CW-1:0]          x_q, x_d, y_q, y_d;  // coordinates of the next tile to issue
    logic [CNT_W-1:0]       inflight_q, inflight_d;
    logic [XF_LAT:0]        pipe_vld_q, pipe_vld_d;
    tile_tag_t [XF_LAT:0]   pipe_tag_q, pipe_tag_d;

    logic                   row_acc, issue, last_tile, credit_ok, push, pop;
    logic [OCC_W-1:0]       occupancy;
    logic [CNT_W-1:0]       fifo_count;
    logic [FIFO_W-1:0]      fifo_dout;
    tile_tag_t              cur_tag, push_tag;

    // Tiles already committed (in the FIFO or still in the transform) may not
    // exceed FIFO depth; pops only free credit once the registered count drops.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    assign credit_ok = occupancy < OCC_W'(OUT_DEPTH);

    assign m_ready   = (state_q == RUN) & ((row_cnt_q != 2'd3) | credit_ok);
    assign row_acc   = m_valid & m_ready;
    assign issue     = row_acc & (row_cnt_q == 2'd3);
    assign last_tile = (x_q == w_q - CW'(1)) & (y_q == h_q - CW'(1));

    assign cur_tag.x = x_q;
    assign cur_tag.y = y_q;

    // Delay line stage 0 loads when xf_M updates; the last stage lines up with
    // the transform result for that tile.
    assign push     = pipe_vld_q[XF_LAT];
    assign push_tag = pipe_tag_q[XF_LAT];
    assign pop      = y_valid & y_ready;

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        rows_d     = rows_q;
        xf_m_d     = xf_m_q;
        w_d        = w_q;
        h_d        = h_q;
        x_d        = x_q;
        y_d        = y_q;
        pipe_vld_d = {pipe_vld_q[XF_LAT-1:0], issue};
        pipe_tag_d = {pipe_tag_q[XF_LAT-1:0], cur_tag};
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);

        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d       = tiles_w;
                    h_d       = tiles_h;
                    x_d       = '0;
                    y_d       = '0;
                    row_cnt_d = 2'd0;
                    state_d   = ((tiles_w != '0) && (tiles_h != '0)) ? RUN : DONE;
                end
            end
            RUN: begin
                if (issue && last_tile) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) && (fifo_count == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (row_acc) begin
            case (row_cnt_q)
                2'd0: rows_d[3*ROW_W-1 -: ROW_W] = m_row;
                2'd1: rows_d[2*ROW_W-1 -: ROW_W] = m_row;
                2'd2: rows_d[ROW_W-1:0]          = m_row;
                default: begin
                    xf_m_d = {rows_q, m_row};
                    if (x_q == w_q - CW'(1)) begin
                        x_d = '0;
                        y_d = y_q + CW'(1);
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end
            endcase
            row_cnt_d = row_cnt_q + 2'd1;   // 3 wraps to 0
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            rows_q     <= '0;
            xf_m_q     <= '0;
            w_q        <= '0;
            h_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            inflight_q <= '0;
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            rows_q     <= rows_d;
            xf_m_q     <= xf_m_d;
            w_q        <= w_d;
            h_q        <= h_d;
            x_q        <= x_d;
            y_q        <= y_d;
            inflight_q <= inflight_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_tag_q <= pipe_tag_d;
        end
    end

    tile_out_fifo #(
        .DW    (FIFO_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .din       ({xf_Y, push_tag}),
        .pop       (pop),
        .dout      (fifo_dout),
        .not_empty (y_valid),
        .count     (fifo_count)
    );

    assign y_data     = fifo_dout[FIFO_W-1 -: TILE_Y_W];
    assign y_tile_x   = fifo_dout[2*CW-1 -: CW];
    assign y_tile_y   = fifo_dout[CW-1:0];
    assign xf_M       = xf_m_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_winograd_output_sequencer.sv
// tb/tb_winograd_output_sequencer.sv - self-checking bench for winograd_output_sequencer
module tb_winograd_output_sequencer;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic [7:0]   tiles_w, tiles_h;
    logic         m_valid;
    logic         m_ready;
    logic [63:0]  m_row;
    logic [255:0] xf_M;
    logic [63:0]  xf_Y;
    logic         y_valid;
    logic         y_ready = 1'b1;
    logic [63:0]  y_data;
    logic [7:0]   y_tile_x, y_tile_y;
    logic         busy, frame_done;

    int n_vec = 0;
    int n_bad = 0;
    int n_pop = 0;
    int fd_cnt = 0;
    int mr_cnt = 0;
    int busy_cnt = 0;
    int yr_mode = 0;                 // 0: always ready, 1: never ready, 2: random
    logic [79:0] sb [$];             // {y_data, x, y}

    winograd_output_sequencer #(.XF_LAT(2), .OUT_DEPTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .tiles_w    (tiles_w),
        .tiles_h    (tiles_h),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_row      (m_row),
        .xf_M       (xf_M),
        .xf_Y       (xf_Y),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_data     (y_data),
        .y_tile_x   (y_tile_x),
        .y_tile_y   (y_tile_y),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Golden output transform Y = A^T * M * A, A^T = [1 1 1 0; 0 1 -1 -1]
    function automatic logic [63:0] xform(input logic [255:0] m);
        logic signed [15:0] e [4][4];
        logic signed [15:0] t [2][4];
        logic signed [15:0] y [2][2];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                e[i][j] = m[255 - 16*(4*i + j) -: 16];
        for (int j = 0; j < 4; j++) begin
            t[0][j] = e[0][j] + e[1][j] + e[2][j];
            t[1][j] = e[1][j] - e[2][j] - e[3][j];
        end
        for (int i = 0; i < 2; i++) begin
            y[i][0] = t[i][0] + t[i][1] + t[i][2];
            y[i][1] = t[i][1] - t[i][2] - t[i][3];
        end
        return {y[0][0], y[0][1], y[1][0], y[1][1]};
    endfunction

    // Transform datapath with two cycles of latency from xf_M to xf_Y
    logic [255:0] xf_s1 = '0;
    logic [63:0]  xf_s2 = '0;
    always @(posedge clk) begin
        xf_s1 <= xf_M;
        xf_s2 <= xform(xf_s1);
    end
    assign xf_Y = xf_s2;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (yr_mode)
            0:       y_ready = 1'b1;
            1:       y_ready = 1'b0;
            default: y_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output scoreboard and status counters, sampled mid-cycle
    always @(negedge clk) begin
        logic [79:0] e;
        if (rstn && y_valid && y_ready) begin
            if (sb.size() == 0) begin
                chk("sb_extra_tile", {y_data, y_tile_x, y_tile_y}, 256'h0);
            end else begin
                e = sb.pop_front();
                chk("y_data", y_data, e[79:16]);
                chk("y_tag", {y_tile_x, y_tile_y}, e[15:0]);
            end
            n_pop++;
        end
        if (frame_done) fd_cnt++;
        if (m_ready)    mr_cnt++;
        if (busy)       busy_cnt++;
    end

    function automatic logic [255:0] rand_tile();
        logic [255:0] m;
        for (int i = 0; i < 8; i++) m[32*i +: 32] = $urandom;
        return m;
    endfunction

    task automatic start_frame(input int w, input int h);
        @(posedge clk); #1;
        start   = 1'b1;
        tiles_w = 8'(w);
        tiles_h = 8'(h);
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // Offers one row until accepted or the budget runs out; returns at edge+1.
    task automatic send_row(input logic [63:0] row, input bit rnd, input int budget, output bit ok);
        ok = 1'b0;
        m_row = row;
        for (int b = 0; b < budget && !ok; b++) begin
            m_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (m_valid && m_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        m_valid = 1'b0;
    endtask

    task automatic send_tile(input logic [255:0] m, input int tx, input int ty, input bit rnd);
        bit ok;
        sb.push_back({xform(m), 8'(tx), 8'(ty)});
        for (int r = 0; r < 4; r++) begin
            send_row(m[255 - 64*r -: 64], rnd, 2000, ok);
            chk("row_accept", 256'(ok), 256'd1);
        end
    endtask

    task automatic wait_done(input int fd0);
        for (int b = 0; b < 20000 && fd_cnt == fd0; b++) @(negedge clk);
        chk("frame_done_seen", 256'(fd_cnt > fd0), 256'd1);
    endtask

    task automatic run_frame(input int w, input int h, input bit rnd);
        int pops0, fd0;
        pops0 = n_pop;
        fd0   = fd_cnt;
        start_frame(w, h);
        for (int ty = 0; ty < h; ty++)
            for (int tx = 0; tx < w; tx++)
                send_tile(rand_tile(), tx, ty, rnd);
        wait_done(fd0);
        repeat (4) @(posedge clk);
        chk("pop_count", 256'(n_pop - pops0), 256'(w * h));
        chk("frame_done_once", 256'(fd_cnt - fd0), 256'd1);
        chk("sb_empty", 256'(sb.size()), 256'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] m1;
        bit           ok;
        int           wait_n, fd0, pops0, mr0, b0;

        rstn = 1'b0; start = 1'b0; m_valid = 1'b0; m_row = '0;
        tiles_w = '0; tiles_h = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_y_valid",    256'(y_valid),    256'd0);
        chk("rst_m_ready",    256'(m_ready),    256'd0);
        chk("rst_busy",       256'(busy),       256'd0);
        chk("rst_frame_done", 256'(frame_done), 256'd0);
        chk("rst_xf_M",       xf_M,             256'd0);
        chk("rst_y_data",     256'(y_data),     256'd0);
        rstn = 1'b1;

        // 1: single tile, hand-computed result and minimum latency
        yr_mode = 0;
        fd0 = fd_cnt; pops0 = n_pop;
        m1 = {{4{16'h0001}}, {4{16'h0002}}, {4{16'h0003}}, {4{16'h0004}}};
        start_frame(1, 1);
        send_tile(m1, 0, 0, 1'b0);
        wait_n = 0;
        for (int b = 0; b < 50; b++) begin
            @(negedge clk);
            if (y_valid) break;
            wait_n++;
        end
        chk("t1_latency", 256'(wait_n), 256'd3);
        chk("t1_y_data", 256'(y_data), 256'h0012_FFFA_FFF1_0005);
        chk("t1_tag", 256'({y_tile_x, y_tile_y}), 256'h0);
        wait_done(fd0);
        chk("t1_pops", 256'(n_pop - pops0), 256'd1);

        // 2: raster order over a 3x2 frame, back-to-back rows
        run_frame(3, 2, 1'b0);

        // 3: backpressure with a full FIFO
        yr_mode = 1;
        fd0 = fd_cnt; pops0 = n_pop;
        start_frame(4, 2);
        for (int t = 0; t < 4; t++) send_tile(rand_tile(), t, 0, 1'b0);
        m1 = rand_tile();
        sb.push_back({xform(m1), 8'd0, 8'd1});
        for (int r = 0; r < 3; r++) begin
            send_row(m1[255 - 64*r -: 64], 1'b0, 50, ok);
            chk("bp_row_accept", 256'(ok), 256'd1);
        end
        send_row(m1[63:0], 1'b0, 20, ok);
        chk("bp_row3_stalled", 256'(ok), 256'd0);
        chk("bp_m_ready_low", 256'(m_ready), 256'd0);
        chk("bp_y_valid", 256'(y_valid), 256'd1);
        chk("bp_head_tag", 256'({y_tile_x, y_tile_y}), 256'h0);
        chk("bp_no_pops", 256'(n_pop - pops0), 256'd0);
        yr_mode = 0;
        send_row(m1[63:0], 1'b0, 2000, ok);
        chk("bp_row3_accept", 256'(ok), 256'd1);
        for (int t = 1; t < 4; t++) send_tile(rand_tile(), t, 1, 1'b0);
        wait_done(fd0);
        repeat (4) @(posedge clk);
        chk("bp_pops", 256'(n_pop - pops0), 256'd8);
        chk("bp_sb_empty", 256'(sb.size()), 256'd0);

        // 4: random valid/ready over 8x8
        yr_mode = 2;
        run_frame(8, 8, 1'b1);
        yr_mode = 0;

        // 5: zero dimension
        fd0 = fd_cnt; mr0 = mr_cnt; b0 = busy_cnt;
        start_frame(0, 3);
        repeat (6) @(posedge clk); #1;
        chk("zd_frame_done", 256'(fd_cnt - fd0), 256'd1);
        chk("zd_m_ready_never", 256'(mr_cnt - mr0), 256'd0);
        chk("zd_busy_seen", 256'(busy_cnt > b0), 256'd1);
        chk("zd_idle_after", 256'(busy), 256'd0);

        // 6: reset mid-frame discards everything
        start_frame(4, 4);
        for (int t = 0; t < 5; t++) send_tile(rand_tile(), t % 4, t / 4, 1'b0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_y_valid", 256'(y_valid), 256'd0);
        chk("mid_rst_busy",    256'(busy),    256'd0);
        chk("mid_rst_m_ready", 256'(m_ready), 256'd0);
        chk("mid_rst_xf_M",    xf_M,          256'd0);
        chk("mid_rst_y_data",  256'(y_data),  256'd0);
        chk("mid_rst_tag",     256'({y_tile_x, y_tile_y}), 256'h0);
        sb.delete();
        repeat (2) @(posedge clk); #1;
        rstn = 1'b1;
        run_frame(2, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
